// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Read-side consumer for the 8x8 byte FIFO. Whenever transmission is enabled
// and the FIFO holds data, one byte is popped and sent on a single line as a
// UART 8N1 frame: idle high, one start bit, 8 data bits LSB first, one stop bit.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   en         transmit enable, only looked at while idle
//   empty      FIFO empty flag, only looked at while idle
//   fifo_data  FIFO read data, valid the cycle after a pop
//   rn         FIFO read strobe, one cycle per pop (flop output)
//   tx         serial line, idles high (flop output)
//   busy       high in every state except IDLE
//   done       one-cycle pulse in the cycle after a stop bit completes
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       empty,
  input  logic [7:0] fifo_data,
  output logic       rn,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [BAUD_W-1:0] baud_r,  baud_s;
  logic [2:0]        bit_r,   bit_s;
  logic [7:0]        shift_r, shift_s;
  logic              tx_s, rn_s, busy_s, done_s;
  logic              baud_end_s;

  // Next-state, counter and next-output logic for the frame sequencer.
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    bit_s      = bit_r;
    shift_s    = shift_r;
    tx_s       = tx;
    done_s     = 1'b0;
    baud_end_s = (baud_r == BAUD_LAST);

    case (state_r)
      IDLE: begin
        tx_s   = 1'b1;
        baud_s = '0;
        bit_s  = 3'd0;
        if (en && !empty) begin
          state_s = POP;
        end else begin
          state_s = IDLE;
        end
      end

      // rn is high during this cycle; the FIFO presents the byte next cycle.
      POP: begin
        state_s = LOAD;
      end

      // Byte is valid now: capture it and start driving the start bit.
      LOAD: begin
        shift_s = fifo_data;
        tx_s    = 1'b0;
        baud_s  = '0;
        state_s = START;
      end

      START: begin
        if (baud_end_s) begin
          baud_s  = '0;
          bit_s   = 3'd0;
          tx_s    = shift_r[0];
          state_s = DATA;
        end else begin
          baud_s  = baud_r + BAUD_ONE;
        end
      end

      // tx already carries shift_r[0]; at each bit boundary the next bit is
      // shift_r[1], which becomes shift[0] after the right shift.
      DATA: begin
        if (baud_end_s) begin
          baud_s = '0;
          if (bit_r == 3'd7) begin
            tx_s    = 1'b1;
            state_s = STOP;
          end else begin
            shift_s = {1'b0, shift_r[7:1]};
            tx_s    = shift_r[1];
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end

      STOP: begin
        tx_s = 1'b1;
        if (baud_end_s) begin
          baud_s  = '0;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          baud_s  = baud_r + BAUD_ONE;
        end
      end

      default: begin
        tx_s    = 1'b1;
        baud_s  = '0;
        bit_s   = 3'd0;
        state_s = IDLE;
      end
    endcase

    // Strobes are decoded from the next state so the flopped outputs line up
    // with the state they describe.
    rn_s   = (state_s == POP);
    busy_s = (state_s != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx      <= 1'b1;
      rn      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx      <= tx_s;
      rn      <= rn_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

endmodule
